// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester arbiter around a single-port RAM; ARB_ROUND_ROBIN_EN selects round-robin tie-break
module ram_arbiter #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  owner,
  output logic                  busy,
  output logic [7:0]            op_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic                  lat_wr;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  pick1;

  // Winner selection: 1 means requester 1 is served; a lone requester always wins
  always_comb begin
    pick1 = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    // on a tie, serve whoever was not served last
    pick1 = req1 && (!req0 || !owner);
`else
    // requester 0 has fixed priority on a tie
    pick1 = req1 && !req0;
`endif
  end

  assign busy = (state != IDLE);

  // Access FSM, RAM and all registered outputs; reset aborts any access and clears the RAM
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done      <= 1'b0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      owner     <= 1'b1;
      op_count  <= 8'd0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state     <= ACC;
            owner     <= pick1;
            gnt0      <= !pick1;
            gnt1      <= pick1;
            lat_wr    <= pick1 ? wr1 : wr0;
            lat_addr  <= pick1 ? addr1 : addr0;
            lat_wdata <= pick1 ? wdata1 : wdata0;
          end
        end
        ACC: begin
          state  <= DONE;
          gnt0   <= 1'b0;
          gnt1   <= 1'b0;
          done   <= 1'b1;
          rvalid <= !lat_wr;
          if (lat_wr) begin
            mem[lat_addr] <= lat_wdata;
          end else begin
            rdata <= mem[lat_addr];
          end
        end
        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          rvalid   <= 1'b0;
          op_count <= op_count + 8'd1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [1:0] addr0 = 2'd0, addr1 = 2'd0;
  logic [3:0] wdata0 = 4'd0, wdata1 = 4'd0;
  logic       gnt0, gnt1, done, rvalid, owner, busy;
  logic [3:0] rdata;
  logic [7:0] op_count;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) dut (
    .clk_2(clk_2), .reset(reset),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done(done), .rvalid(rvalid),
    .rdata(rdata), .owner(owner), .busy(busy), .op_count(op_count)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one rising edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  logic exp1;

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_done", done, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_owner", owner, 1);
    check("rst_opcnt", op_count, 0);
    check("rst_busy", busy, 0);

    // write 9 to address 2 from requester 0
    req0 = 1; wr0 = 1; addr0 = 2; wdata0 = 9;
    tick();
    req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
    check("w_gnt0", gnt0, 1);
    check("w_gnt1", gnt1, 0);
    check("w_busy", busy, 1);
    check("w_owner", owner, 0);
    tick();
    check("w_gnt0_off", gnt0, 0);
    check("w_done", done, 1);
    check("w_rvalid", rvalid, 0);
    tick();
    check("w_done_off", done, 0);
    check("w_opcnt", op_count, 1);
    check("w_idle", busy, 0);

    // read address 2 from requester 1
    req1 = 1; wr1 = 0; addr1 = 2;
    tick();
    req1 = 0; addr1 = 0;
    check("r_gnt1", gnt1, 1);
    check("r_gnt0", gnt0, 0);
    check("r_owner", owner, 1);
    tick();
    check("r_done", done, 1);
    check("r_rvalid", rvalid, 1);
    check("r_rdata", rdata, 9);
    tick();
    check("r_rvalid_off", rvalid, 0);
    check("r_opcnt", op_count, 2);

    // both requesting for 12 cycles (reads of address 2); owner is 1 so 0 wins first tie
    req0 = 1; req1 = 1; wr0 = 0; wr1 = 0; addr0 = 2; addr1 = 2;
    for (int i = 1; i <= 12; i++) begin
      if (i == 12) begin
        req0 = 0; req1 = 0;
      end
      tick();
      if (i % 3 == 1) begin
`ifdef ARB_ROUND_ROBIN_EN
        exp1 = ((i / 3) % 2) == 1;
`else
        exp1 = 1'b0;
`endif
        check("tie_gnt0", gnt0, !exp1);
        check("tie_gnt1", gnt1, exp1);
      end else begin
        check("tie_gnt0_idle", gnt0, 0);
        check("tie_gnt1_idle", gnt1, 0);
      end
    end
    req0 = 0; req1 = 0;
    check("tie_opcnt", op_count, 6);
    check("tie_rdata", rdata, 9);
    check("tie_busy", busy, 0);

    // write 0xF to address 3, then read it straight back
    req0 = 1; wr0 = 1; addr0 = 3; wdata0 = 4'hF;
    tick();
    req0 = 0; wr0 = 0;
    tick();
    tick();
    req0 = 1; wr0 = 0; addr0 = 3;
    tick();
    req0 = 0;
    tick();
    check("raw_rdata", rdata, 4'hF);
    check("raw_rvalid", rvalid, 1);
    tick();
    check("raw_opcnt", op_count, 8);

    // start a write of 5 to address 3 and reset during its ACC cycle
    req0 = 1; wr0 = 1; addr0 = 3; wdata0 = 5;
    tick();
    req0 = 0; wr0 = 0;
    check("abort_gnt0_pre", gnt0, 1);
    reset = 1;
    #1;
    check("abort_gnt0", gnt0, 0);
    check("abort_busy", busy, 0);
    check("abort_opcnt", op_count, 0);
    check("abort_owner", owner, 1);
    check("abort_rdata", rdata, 0);
    #1;
    reset = 0;
    tick();
    check("abort_no_done", done, 0);
    check("abort_no_rvalid", rvalid, 0);
    req1 = 1; wr1 = 0; addr1 = 3;
    tick();
    req1 = 0;
    check("post_gnt1", gnt1, 1);
    tick();
    check("post_rvalid", rvalid, 1);
    check("post_rdata", rdata, 0);
    tick();
    check("post_opcnt", op_count, 1);

    // 256 single accesses from a fresh reset: op_count wraps to 0
    reset = 1;
    #2;
    reset = 0;
    for (int i = 0; i < 256; i++) begin
      req0 = 1; wr0 = 0; addr0 = 0;
      tick();
      req0 = 0;
      tick();
      tick();
      check("wrap_idle_busy", busy, 0);
      if (i == 254) check("wrap_255", op_count, 255);
      if (i == 255) check("wrap_0", op_count, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
